pixel_stream_controller: RTL and testbench

Sequencer that, after the vector core finishes alpha composition, takes ownership of the DataMemory port. It streams the composed image out as RGB pixels. For each group of 4 pixels it issues three vector reads (vf=1), one each to the R, G and B planes, then emits 4 pixels on a valid/ready stream. It sits between the core's memory-port mux and the output/display interface.

---
 rtl/pixel_stream_controller.sv | 158 +++++++++++++++
 tb/tb_pixel_stream_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_controller.sv
// Streams a composed RGB image out of DataMemory: three vector reads (R, G, B planes)
// per group of four pixels, then four pixels on a valid/ready stream.
module pixel_stream_controller #(
  parameter int unsigned PIXELS = 40000,
  parameter int unsigned R_BASE = 0,
  parameter int unsigned G_BASE = 40000,
  parameter int unsigned B_BASE = 80000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         mem_own,
  output logic [127:0] mem_addr,
  output logic         mem_we,
  output logic         mem_vf,
  input  logic [127:0] mem_rd,
  output logic [23:0]  pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_last
);

  localparam int unsigned OFF_W = $clog2(PIXELS);

  typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, SEND, DONE} state_t;

  state_t           state_reg, state_next;
  logic [OFF_W-1:0] offset_reg, offset_next;
  logic [1:0]       lane_reg, lane_next;
  logic [7:0]       r_reg [4];
  logic [7:0]       g_reg [4];
  logic [7:0]       b_reg [4];
  logic [7:0]       r_next [4];
  logic [7:0]       g_next [4];
  logic [7:0]       b_next [4];

  logic             busy_next, done_next, own_next, valid_next, last_next;
  logic [31:0]      addr_next;
  logic [23:0]      data_next;

  // Only the low byte of each 32-bit lane carries a pixel component.
  logic [7:0]       rd_lane [4];
  logic [23:0]      rd_pad [4];
  logic             unused_rd_pad;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = mem_rd[32*gi +: 8];
    assign rd_pad[gi]  = mem_rd[32*gi+8 +: 24];
  end
  assign unused_rd_pad = ^{rd_pad[0], rd_pad[1], rd_pad[2], rd_pad[3]};

  assign mem_we = 1'b0;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    lane_next   = lane_reg;
    r_next      = r_reg;
    g_next      = g_reg;
    b_next      = b_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RD_R;
          offset_next = '0;
          lane_next   = 2'd0;
        end
      end
      RD_R: begin
        for (int i = 0; i < 4; i++) r_next[i] = rd_lane[i];
        state_next = RD_G;
      end
      RD_G: begin
        for (int i = 0; i < 4; i++) g_next[i] = rd_lane[i];
        state_next = RD_B;
      end
      RD_B: begin
        for (int i = 0; i < 4; i++) b_next[i] = rd_lane[i];
        state_next = SEND;
        lane_next  = 2'd0;
      end
      SEND: begin
        if (pix_ready) begin
          if (lane_reg != 2'd3) begin
            lane_next = lane_reg + 2'd1;
          end else if ((32'(offset_reg) + 32'd4) == PIXELS) begin
            state_next = DONE;
          end else begin
            offset_next = offset_reg + OFF_W'(4);
            state_next  = RD_R;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the next-state values so they come straight out of flops.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    own_next  = (state_next == RD_R) || (state_next == RD_G) ||
                (state_next == RD_B) || (state_next == SEND);
    case (state_next)
      RD_R:    addr_next = R_BASE + 32'(offset_next);
      RD_G:    addr_next = G_BASE + 32'(offset_next);
      RD_B:    addr_next = B_BASE + 32'(offset_next);
      default: addr_next = 32'd0;
    endcase
    valid_next = (state_next == SEND);
    last_next  = valid_next && (lane_next == 2'd3) &&
                 ((32'(offset_next) + 32'd4) == PIXELS);
    data_next  = pix_data;
    if (valid_next) begin
      data_next = {r_next[lane_next], g_next[lane_next], b_next[lane_next]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      offset_reg <= '0;
      lane_reg   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_reg[i] <= 8'd0;
        g_reg[i] <= 8'd0;
        b_reg[i] <= 8'd0;
      end
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_own   <= 1'b0;
      mem_vf    <= 1'b0;
      mem_addr  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_data  <= 24'd0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      lane_reg   <= lane_next;
      r_reg      <= r_next;
      g_reg      <= g_next;
      b_reg      <= b_next;
      busy       <= busy_next;
      done       <= done_next;
      mem_own    <= own_next;
      mem_vf     <= own_next;
      mem_addr   <= {96'd0, addr_next};
      pix_valid  <= valid_next;
      pix_last   <= last_next;
      pix_data   <= data_next;
    end
  end

endmodule

// File: tb/tb_pixel_stream_controller.sv
// Bench for pixel_stream_controller: an 8-pixel instance for frame-level scenarios and a
// default-size instance for the bank-boundary group, both checked every cycle against a model.
module tb_pixel_stream_controller;

  localparam int unsigned R_B = 0;
  localparam int unsigned G_B = 40000;
  localparam int unsigned B_B = 80000;
  localparam logic [7:0]  KEY = 8'h5A;

  typedef enum int {K_IDLE, K_READ, K_PIX, K_DONE} kind_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   start_v = 2'b00;
  logic [1:0]   ready_v = 2'b11;
  logic [1:0]   busy_v, done_v, own_v, we_v, vf_v, valid_v, last_v;
  logic [127:0] addr_a [2];
  logic [127:0] rd_a [2];
  logic [23:0]  data_a [2];

  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 0;
  int unsigned ready_cyc = 0;
  logic [23:0] got0 [$];

  always #5 clk = ~clk;

  // Memory image: planes hold 1..8, 11..18, 21..28 in their first 8 bytes, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input longint unsigned a);
    longint unsigned p;
    longint unsigned plane;
    p = a % 40000;
    plane = a / 40000;
    if (p < 8) return 8'(p + 1 + 10 * plane);
    return 8'((a * 131) >> 3) ^ KEY;
  endfunction

  function automatic logic [23:0] pixel(input int unsigned p);
    return {mem_byte(64'(R_B + p)), mem_byte(64'(G_B + p)), mem_byte(64'(B_B + p))};
  endfunction

  task automatic chk(input int inst, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL i%0d %s: got %0h expected %0h", inst, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ready_cyc++;
    case (ready_mode)
      0:       ready_v[0] = 1'b1;
      1:       ready_v[0] = ((ready_cyc % 4) == 0) || ((ready_cyc % 4) == 3);
      default: ready_v[0] = 1'($urandom_range(0, 1));
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned NPIX = (gi == 0) ? 8 : 40000;

    pixel_stream_controller #(.PIXELS(NPIX)) dut (
      .clk(clk), .rst(rst), .start(start_v[gi]), .busy(busy_v[gi]), .done(done_v[gi]),
      .mem_own(own_v[gi]), .mem_addr(addr_a[gi]), .mem_we(we_v[gi]), .mem_vf(vf_v[gi]),
      .mem_rd(rd_a[gi]), .pix_data(data_a[gi]), .pix_valid(valid_v[gi]),
      .pix_ready(ready_v[gi]), .pix_last(last_v[gi])
    );

    logic [23:0] junk;
    always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
        junk = 24'($urandom);
        rd_a[gi][32*i +: 32] = {junk, mem_byte(addr_a[gi][63:0] + 64'(i))};
      end
    end

    kind_t       kind = K_IDLE;
    bit          active = 1'b0;
    int unsigned reads = 0;
    int unsigned npix = 0;
    int unsigned exp_addr;
    logic [23:0] prev_data = '0;

    always begin
      @(posedge clk);
      #1;
      if (rst) begin
        active = 1'b0; reads = 0; npix = 0; kind = K_IDLE;
        chk(gi, "rst busy", 128'(busy_v[gi]), 128'(0));
        chk(gi, "rst done", 128'(done_v[gi]), 128'(0));
        chk(gi, "rst mem_own", 128'(own_v[gi]), 128'(0));
        chk(gi, "rst mem_vf", 128'(vf_v[gi]), 128'(0));
        chk(gi, "rst mem_addr", addr_a[gi], 128'(0));
        chk(gi, "rst pix_valid", 128'(valid_v[gi]), 128'(0));
        chk(gi, "rst pix_last", 128'(last_v[gi]), 128'(0));
        chk(gi, "rst pix_data", 128'(data_a[gi]), 128'(0));
      end else begin
        // Account for what happened at the edge just taken.
        case (kind)
          K_IDLE: if (start_v[gi]) begin active = 1'b1; reads = 0; npix = 0; end
          K_READ: reads++;
          K_PIX: if (ready_v[gi]) begin
            if (gi == 0) got0.push_back(prev_data);
            npix++;
          end
          K_DONE: active = 1'b0;
          default: ;
        endcase
        if (!active) kind = K_IDLE;
        else if (npix == NPIX) kind = K_DONE;
        else if (reads < 3 * (npix / 4 + 1)) kind = K_READ;
        else kind = K_PIX;

        exp_addr = 0;
        if (kind == K_READ)
          exp_addr = ((reads % 3 == 0) ? R_B : (reads % 3 == 1) ? G_B : B_B) + 4 * (reads / 3);
        chk(gi, "busy", 128'(busy_v[gi]), 128'(kind != K_IDLE));
        chk(gi, "done", 128'(done_v[gi]), 128'(kind == K_DONE));
        chk(gi, "mem_own", 128'(own_v[gi]), 128'(kind == K_READ || kind == K_PIX));
        chk(gi, "mem_vf", 128'(vf_v[gi]), 128'(kind == K_READ || kind == K_PIX));
        chk(gi, "mem_we", 128'(we_v[gi]), 128'(0));
        chk(gi, "mem_addr", addr_a[gi], 128'(exp_addr));
        chk(gi, "pix_valid", 128'(valid_v[gi]), 128'(kind == K_PIX));
        chk(gi, "pix_last", 128'(last_v[gi]), 128'(kind == K_PIX && npix == NPIX - 1));
        if (kind == K_PIX) chk(gi, "pix_data", 128'(data_a[gi]), 128'(pixel(npix)));
      end
      prev_data = data_a[gi];
    end
  end

  task automatic run_frame(input bit poke, input int budget, output int cyc);
    bit seen;
    bit poked;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 1; seen = 1'b0; poked = 1'b0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_v[0]) seen = 1'b1;
      else if (poke && valid_v[0] && !poked) begin
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        poked = 1'b1;
      end
    end
    chk(0, "done within budget", 128'(seen), 128'(1));
  endtask

  initial begin
    int  cyc;
    bit  found;
    logic [127:0] step_addr [1:9];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Full frame with the sink always ready.
    ready_mode = 0; got0.delete();
    run_frame(1'b0, 100, cyc);
    chk(0, "latency", 128'(cyc), 128'(15));
    chk(0, "pixel count", 128'(got0.size()), 128'(8));
    if (got0.size() == 8) begin
      chk(0, "pixel0", 128'(got0[0]), 128'(24'h010B15));
      chk(0, "pixel1", 128'(got0[1]), 128'(24'h020C16));
      chk(0, "pixel7", 128'(got0[7]), 128'(24'h08121C));
    end

    // Sink toggling 1,0,0,1.
    ready_mode = 1; got0.delete();
    run_frame(1'b0, 200, cyc);
    chk(0, "stall count", 128'(got0.size()), 128'(8));
    if (got0.size() == 8) begin
      chk(0, "stall pixel3", 128'(got0[3]), 128'(24'h040E18));
      chk(0, "stall pixel7", 128'(got0[7]), 128'(24'h08121C));
    end

    // start during SEND and during DONE is dropped.
    ready_mode = 2; got0.delete();
    run_frame(1'b1, 200, cyc);
    chk(0, "poke count", 128'(got0.size()), 128'(8));
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk(0, "idle after done-start", 128'(busy_v[0]), 128'(0));
    got0.delete();
    run_frame(1'b0, 200, cyc);
    chk(0, "restart count", 128'(got0.size()), 128'(8));
    if (got0.size() > 0) chk(0, "restart pixel0", 128'(got0[0]), 128'(24'h010B15));

    // Asynchronous reset in RD_G of the second group.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (addr_a[0] == 128'(G_B + 4)) found = 1'b1;
    end
    chk(0, "reached RD_G group1", 128'(found), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk(0, "async busy", 128'(busy_v[0]), 128'(0));
    chk(0, "async mem_own", 128'(own_v[0]), 128'(0));
    chk(0, "async mem_vf", 128'(vf_v[0]), 128'(0));
    chk(0, "async mem_addr", addr_a[0], 128'(0));
    chk(0, "async pix_data", 128'(data_a[0]), 128'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    got0.delete();
    run_frame(1'b0, 100, cyc);
    chk(0, "post-reset latency", 128'(cyc), 128'(15));
    if (got0.size() > 0) chk(0, "post-reset pixel0", 128'(got0[0]), 128'(24'h010B15));

    // Random sink behaviour and gaps between frames.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      got0.delete();
      run_frame(1'b0, 300, cyc);
      chk(0, "random frame count", 128'(got0.size()), 128'(8));
    end

    // Default-size instance: group at offset 9996 and the following group at 10000.
    ready_mode = 0;
    @(negedge clk); start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (addr_a[1] == 128'(9996)) found = 1'b1;
    end
    chk(1, "reached offset 9996", 128'(found), 128'(1));
    step_addr[1] = 128'(49996); step_addr[2] = 128'(89996);
    for (int s = 3; s <= 6; s++) step_addr[s] = 128'(0);
    step_addr[7] = 128'(10000); step_addr[8] = 128'(50000); step_addr[9] = 128'(90000);
    for (int s = 1; s <= 9; s++) begin
      @(posedge clk);
      #1;
      chk(1, $sformatf("boundary addr step%0d", s), addr_a[1], step_addr[s]);
    end
    @(posedge clk);
    #1;
    chk(1, "pixel10000 valid", 128'(valid_v[1]), 128'(1));
    chk(1, "pixel10000 data", 128'(data_a[1]), 128'(24'hFC648C));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
